adder_share_sched: RTL and testbench
====================================

// Module: adder_share_sched
// PURPOSE
//   Time-multiplexes one external WIDTH-bit ripple-carry adder (adder_gate) between NREQ
//   requesters, e.g. neuron-update lanes accumulating membrane potentials.
//   Arbitration is round-robin. The block registers the operands, waits a programmable
//   settle time for the ripple chain, captures the WIDTH+1-bit sum and returns it to the
//   winning requester over a valid/ready response.
// PARAMETERS
//   WIDTH          8  operand width; sum is WIDTH+1 bits (carry-out kept)
//   NREQ           4  number of requesters (>=2)
//   SETTLE_CYCLES  2  cycles between the operand register update and sum capture (>=1)
// PORTS
//   clk         in   1             clock, all state on rising edge
//   rst_n       in   1             reset, asynchronous, active-low
//   req_valid   in   NREQ          per-requester request valid
//   req_ready   out  NREQ          one-hot accept strobe (combinational)
//   req_opa     in   NREQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//   req_opb     in   NREQ*WIDTH    operand B, same packing
//   rsp_valid   out  NREQ          one-hot response valid
//   rsp_ready   in   NREQ          per-requester response ready
//   rsp_sum     out  WIDTH+1       captured sum, shared by all requesters
//   add_opa     out  WIDTH         registered operand A to the adder
//   add_opb     out  WIDTH         registered operand B to the adder
//   add_sum     in   WIDTH+1       adder result
//   busy        out  1             1 whenever state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, rr_ptr=0, grant_id=0, cnt=0.
//   add_opa, add_opb, rsp_sum = 0; req_ready, rsp_valid = 0; busy = 0.
// - FSM has three states: IDLE -> SETTLE -> RESP -> IDLE.
// - IDLE:
//   - g = first index with req_valid[g]=1, searching from rr_ptr upward and wrapping modulo NREQ.
//   - If any request is valid: req_ready[g]=1 in this cycle only.
//   - Clock edge: add_opa/add_opb <= operands of g; grant_id <= g;
//     rr_ptr <= (g+1) mod NREQ; cnt <= SETTLE_CYCLES-1; go to SETTLE.
//   - If no request is valid: hold state, all outputs low.
// - SETTLE:
//   - cnt>0: decrement cnt.
//   - cnt==0: rsp_sum <= add_sum; go to RESP.
// - RESP:
//   - rsp_valid[grant_id]=1; all other rsp_valid bits are 0.
//   - rsp_sum and grant_id hold stable until rsp_ready[grant_id]=1.
//   - Then go to IDLE on that edge. rsp_valid drops next cycle; rsp_sum keeps its last value.
//   - rsp_ready of non-granted requesters is ignored.
// - Timing:
//   - Accept at cycle T -> rsp_valid high from T+1+SETTLE_CYCLES.
//   - Minimum spacing between accepts is SETTLE_CYCLES+2 cycles.
//   - There is no accept in the same cycle as a response handshake.
// - req_ready is 0 outside IDLE. Requesters hold req_valid and operands until accepted.
//   A request withdrawn before acceptance is simply not served.
// - Arithmetic is unsigned. Carry-out lands in rsp_sum[WIDTH]; no truncation or saturation.
// - Reset mid-operation: the transaction is dropped with no response; outputs return to reset values at once.
// - rr_ptr advances only on accept. Grants follow a fixed rotation, so no requester starves.
// TESTING
// 1. Requester 0 sends opa=8'hFF, opb=8'h01, rsp_ready=1, SETTLE_CYCLES=2.
//    -> req_ready=4'b0001 at T; rsp_valid=4'b0001 at T+3; rsp_sum=9'h100.
// 2. All 4 req_valid held high, rsp_ready=4'hF.
//    -> grants in order 0,1,2,3,0, one accept every 4 cycles.
// 3. Response backpressure: rsp_ready[1]=0 for 5 cycles during RESP.
//    -> rsp_valid[1] and rsp_sum held constant; req_ready=0 throughout; busy=1.
// 4. rr_ptr=3, requests on 1 and 3.
//    -> 3 served first, then 1 (wrap-around); rr_ptr ends at 2.
// 5. rst_n pulsed low while in SETTLE.
//    -> all outputs 0 immediately and no response. After release, a request on 2 is granted
//       (search starts from rr_ptr=0).
// 6. SETTLE_CYCLES=1, 1000 random ops from random requesters with random rsp_ready.
//    -> every sum == opa+opb (9-bit), delivered to the issuing requester, rsp_valid one-hot.

Source files
------------

// File: rtl/adder_share_sched.sv
// -----------------------------------------------------------------------------
// adder_share_sched
//
// Shares one external WIDTH-bit ripple-carry adder between NREQ requesters.
// A round-robin arbiter picks one valid requester while idle, registers its
// operands onto the adder inputs, waits SETTLE_CYCLES for the carry chain to
// settle, captures the WIDTH+1-bit sum and returns it to that requester over a
// valid/ready response. The next search starts one past the last winner, so
// every requester is reached within NREQ grants.
//
// Ports
//   clk        in   1            clock, all state on rising edge
//   rst_n      in   1            asynchronous active-low reset
//   req_valid  in   NREQ         per-requester request valid
//   req_ready  out  NREQ         one-hot accept strobe (combinational, IDLE only)
//   req_opa    in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_opb    in   NREQ*WIDTH   operand B, same packing
//   rsp_valid  out  NREQ         one-hot response valid (RESP only)
//   rsp_ready  in   NREQ         per-requester response ready
//   rsp_sum    out  WIDTH+1      captured sum, shared by all requesters
//   add_opa    out  WIDTH        registered operand A to the external adder
//   add_opb    out  WIDTH        registered operand B to the external adder
//   add_sum    in   WIDTH+1      external adder result
//   busy       out  1            high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module adder_share_sched #(
  parameter int WIDTH         = 8,
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_opa,
  input  logic [NREQ*WIDTH-1:0]   req_opb,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [WIDTH:0]          rsp_sum,
  output logic [WIDTH-1:0]        add_opa,
  output logic [WIDTH-1:0]        add_opb,
  input  logic [WIDTH:0]          add_sum,
  output logic                    busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // The counter only ever holds values 0..SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Modulo-NREQ increment that also works when NREQ is not a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int               off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // State
  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_grant_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH:0]     r_sum;

  // Arbiter / control
  logic               w_any;
  logic [PTR_W-1:0]   w_grant;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_accept;
  logic               w_capture;

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default before any branch, so no
    // path can leave it unassigned and no latch is inferred.
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_any   = 1'b1;
        w_grant = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_next_ptr = wrap_add(w_grant, 1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process ordering.
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready   = ONE_HOT0 << w_grant;
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // add_opa/add_opb have been stable since the accept edge; once the
        // countdown reaches zero the ripple chain has had SETTLE_CYCLES.
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = ONE_HOT0 << r_grant_id;
        // Only the granted requester's ready completes the response.
        if (rsp_ready[r_grant_id]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand registers, grant bookkeeping, settle counter, sum capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_sum      <= '0;
    end else begin
      if (w_accept) begin
        r_opa      <= req_opa[w_grant*WIDTH +: WIDTH];
        r_opb      <= req_opb[w_grant*WIDTH +: WIDTH];
        r_grant_id <= w_grant;
        r_rr_ptr   <= w_next_ptr;
        r_cnt      <= CNT_INIT;
      end else if (r_state == ST_SETTLE && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_capture) begin
        r_sum <= add_sum;
      end
    end
  end

  assign add_opa = r_opa;
  assign add_opb = r_opb;
  assign rsp_sum = r_sum;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_share_sched.sv
// -----------------------------------------------------------------------------
// tb_adder_share_sched
//
// Directed bench for adder_share_sched. Instance u_dut runs with
// SETTLE_CYCLES=2 for the directed scenarios; u_dut1 runs with SETTLE_CYCLES=1
// for the randomized traffic run. Each instance sees a behavioural model of the
// external ripple adder. Inputs change 2 time units after the rising edge and
// outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_adder_share_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---- u_dut (SETTLE_CYCLES = 2) ----
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_opa = '0;
  logic [N*W-1:0] req_opb = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W:0]     rsp_sum;
  logic [W-1:0]   add_opa;
  logic [W-1:0]   add_opb;
  logic [W:0]     add_sum;
  logic           busy;

  // ---- u_dut1 (SETTLE_CYCLES = 1) ----
  logic [N-1:0]   req_valid1 = '0;
  logic [N-1:0]   req_ready1;
  logic [N*W-1:0] req_opa1 = '0;
  logic [N*W-1:0] req_opb1 = '0;
  logic [N-1:0]   rsp_valid1;
  logic [N-1:0]   rsp_ready1 = '0;
  logic [W:0]     rsp_sum1;
  logic [W-1:0]   add_opa1;
  logic [W-1:0]   add_opb1;
  logic [W:0]     add_sum1;
  logic           busy1;

  // External ripple adders (combinational model).
  assign add_sum  = {1'b0, add_opa}  + {1'b0, add_opb};
  assign add_sum1 = {1'b0, add_opa1} + {1'b0, add_opb1};

  adder_share_sched #(.WIDTH(W), .NREQ(N), .SETTLE_CYCLES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opa   (req_opa),
    .req_opb   (req_opb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .add_opa   (add_opa),
    .add_opb   (add_opb),
    .add_sum   (add_sum),
    .busy      (busy)
  );

  adder_share_sched #(.WIDTH(W), .NREQ(N), .SETTLE_CYCLES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_opa   (req_opa1),
    .req_opb   (req_opb1),
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready1),
    .rsp_sum   (rsp_sum1),
    .add_opa   (add_opa1),
    .add_opb   (add_opb1),
    .add_sum   (add_sum1),
    .busy      (busy1)
  );

  // Hand-computed per-lane operands and sums for the directed tests.
  //   lane0: FF + 01 = 100   lane1: 7F + 01 = 080
  //   lane2: AA + 55 = 0FF   lane3: C8 + 64 = 12C
  logic [W-1:0] opa_tab [N];
  logic [W-1:0] opb_tab [N];
  logic [W:0]   sum_tab [N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One full transaction on u_dut, assuming rsp_ready is all ones and the
  // caller has already set req_valid for the accept cycle.
  task automatic serve(input int g);
    #1;
    check("accept_ready", 32'(req_ready), 32'(1) << g);
    check("accept_busy", 32'(busy), 32'd0);
    tick();
    req_valid[g] = 1'b0;
    #1;
    check("settle_ready", 32'(req_ready), 32'd0);
    check("settle_busy", 32'(busy), 32'd1);
    check("settle_opa", 32'(add_opa), 32'(opa_tab[g]));
    check("settle_opb", 32'(add_opb), 32'(opb_tab[g]));
    tick();
    check("rsp_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'(1) << g);
    check("rsp_sum", 32'(rsp_sum), 32'(sum_tab[g]));
    tick();
    check("rsp_dropped", 32'(rsp_valid), 32'd0);
    check("rsp_sum_kept", 32'(rsp_sum), 32'(sum_tab[g]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
    check({tag, "_add_opa"},   32'(add_opa),   32'd0);
    check({tag, "_add_opb"},   32'(add_opb),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Random-run scratch
  int           r6;
  logic [W-1:0] a6;
  logic [W-1:0] b6;
  logic [W:0]   s6;
  logic         done6;

  initial begin
    opa_tab[0] = 8'hFF; opb_tab[0] = 8'h01; sum_tab[0] = 9'h100;
    opa_tab[1] = 8'h7F; opb_tab[1] = 8'h01; sum_tab[1] = 9'h080;
    opa_tab[2] = 8'hAA; opb_tab[2] = 8'h55; sum_tab[2] = 9'h0FF;
    opa_tab[3] = 8'hC8; opb_tab[3] = 8'h64; sum_tab[3] = 9'h12C;
    for (int i = 0; i < N; i++) begin
      req_opa[i*W +: W] = opa_tab[i];
      req_opb[i*W +: W] = opb_tab[i];
    end
    rsp_ready = 4'hF;

    // ---- Reset state ----
    rst_n = 1'b0;
    #3;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // ---- 1: single request, carry-out ----
    req_valid = 4'b0001;
    serve(0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // ---- 2: all requesters valid, rotation 0,1,2,3,0 every 4 cycles ----
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset2");
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 4'hF;
    serve(0); req_valid = 4'hF;
    serve(1); req_valid = 4'hF;
    serve(2); req_valid = 4'hF;
    serve(3); req_valid = 4'hF;
    serve(0);
    req_valid = 4'h0;

    // ---- 3: response backpressure on requester 1 (rr_ptr now 1) ----
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    #1;
    check("t3_accept", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1101;
    #1;
    check("t3_settle_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", 32'(rsp_valid), 32'b0010);
      check("t3_hold_sum", 32'(rsp_sum), 32'h080);
      check("t3_hold_ready", 32'(req_ready), 32'd0);
      check("t3_hold_busy", 32'(busy), 32'd1);
      tick();
    end
    req_valid = 4'h0;
    rsp_ready = 4'hF;
    #1;
    check("t3_before_hs", 32'(rsp_valid), 32'b0010);
    tick();
    check("t3_after_hs", 32'(rsp_valid), 32'd0);
    check("t3_after_busy", 32'(busy), 32'd0);

    // ---- 4: wrap-around from rr_ptr=3 with requests on 1 and 3 ----
    req_valid = 4'b0100;
    serve(2);                   // rr_ptr -> 3
    req_valid = 4'b1010;
    serve(3);                   // 3 first
    serve(1);                   // then 1 (wrap); rr_ptr -> 2
    req_valid = 4'hF;
    serve(2);                   // search starts at 2; rr_ptr -> 3
    req_valid = 4'h0;

    // ---- 5: reset during SETTLE (rr_ptr is 3 before reset) ----
    req_valid = 4'b0100;
    #1;
    check("t5_accept", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'h0;
    #3;
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_mid");
    tick();
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b1100;        // reset rr_ptr=0 favours 2 over 3
    serve(2);
    req_valid = 4'h0;

    // ---- 6: SETTLE_CYCLES=1, random traffic and random rsp_ready ----
    for (int n = 0; n < 1000; n++) begin
      r6 = $urandom_range(0, N - 1);
      req_opa1 = $urandom;
      req_opb1 = $urandom;
      a6 = req_opa1[r6*W +: W];
      b6 = req_opb1[r6*W +: W];
      s6 = {1'b0, a6} + {1'b0, b6};
      req_valid1 = 4'b0001 << r6;
      rsp_ready1 = 4'($urandom_range(0, 15));
      #1;
      check("r_accept", 32'(req_ready1), 32'(1) << r6);
      tick();
      req_valid1 = 4'h0;
      req_opa1   = $urandom;    // operands are free to change after accept
      req_opb1   = $urandom;
      rsp_ready1 = 4'($urandom_range(0, 15));
      #1;
      check("r_settle", 32'(rsp_valid1), 32'd0);
      tick();
      done6 = 1'b0;
      for (int c = 0; c < 16 && !done6; c++) begin
        rsp_ready1 = (c == 15) ? 4'hF : 4'($urandom_range(0, 15));
        #1;
        check("r_valid", 32'(rsp_valid1), 32'(1) << r6);
        check("r_sum", 32'(rsp_sum1), 32'(s6));
        done6 = rsp_ready1[r6];
        tick();
      end
      check("r_done_valid", 32'(rsp_valid1), 32'd0);
      check("r_done_busy", 32'(busy1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
